dec4b5b: RTL and testbench
==========================

# dec4b5b

Receive-side 4B/5B decoder for the 100BASE-FX link. It takes the NRZ bit stream, which has already been NRZI-decoded and bit-recovered, and searches it for the J/K start-of-stream delimiter. After a J/K match it locks 5-bit code-group alignment and converts data code groups back to nibbles. It detects the T/R end-of-stream delimiter and flags coding errors, and it feeds the MAC receive path that sits downstream of the bit-recovery logic.

## Interface
Parameters:
- P_MAX_NIBBLES, 3056: maximum data nibbles per frame. Only used when DEC4B5B_MAXLEN_EN is defined.

Ports:
- i_clk  input  1  system clock. One clock only.
- i_res_n  input  1  asynchronous, active-low reset.
- i_bit  input  1  received code bit. Bit 4 of each code group arrives first (MSB first).
- i_bit_en  input  1  i_bit is valid this cycle. The block does nothing on cycles without it.
- o_data  output  4  decoded nibble. Valid when o_valid=1.
- o_valid  output  1  one-cycle strobe: a new decoded code group is reported.
- o_rx_dv  output  1  level: a frame is in progress.
- o_rx_er  output  1  one-cycle error strobe.
- o_frame_done  output  1  one-cycle strobe: the frame ended cleanly with T followed by R.

## Operation
- Shift register: sr[9:0] <= {sr[8:0], i_bit} on every i_bit_en, in all states.
- Phase counter ph: 0..4, counts bits within the current code group.
- Code group under evaluation: cg = {sr[3:0], i_bit}, taken on the i_bit_en cycle where ph==4.

States:
- S_HUNT (after reset)
  - On i_bit_en, test the next window {sr[8:0], i_bit}.
  - If the window equals 11000_10001 (J,K): go to S_DATA, ph<=0, nibble count<=0.
  - No outputs are produced in this state.
- S_DATA
  - ph advances on each i_bit_en and wraps 4->0.
  - At ph==4, decode cg using the standard table:
    - 11110=0, 01001=1, 10100=2, 10101=3, 01010=4, 01011=5, 01110=6, 01111=7
    - 10010=8, 10011=9, 10110=A, 10111=B, 11010=C, 11011=D, 11100=E, 11101=F
  - Data code group: o_data<=nibble, o_valid<=1, o_rx_dv<=1; stay in S_DATA.
  - T (01101): o_rx_dv<=0; go to S_END.
  - IDLE (11111): premature end. o_rx_er<=1, o_rx_dv<=0; go to S_HUNT.
  - Any other code group: o_valid<=1, o_rx_er<=1, o_data<=4'h0; stay in S_DATA with o_rx_dv unchanged.
- S_END
  - Collect the next code group the same way.
  - R (00111): o_frame_done<=1.
  - Anything else: o_rx_er<=1.
  - In both cases go to S_HUNT.

Other rules:
- J/K is not delivered as data.
- o_rx_dv rises together with the first data o_valid.
- Reset at any point returns the block to S_HUNT. Any frame in progress is dropped with no strobes.

## Timing
- Reset values:
  - o_data=0, o_valid=0, o_rx_dv=0, o_rx_er=0, o_frame_done=0
  - sr=0, ph=0, state=S_HUNT
- All outputs are registered. Strobes appear on the cycle after the i_bit_en that carried the last bit of a code group.
- Strobes are exactly one cycle wide, even if i_bit_en is high on consecutive cycles.
- Latency from the last bit of a code group to o_valid: 1 clock.
- Gaps in i_bit_en stall ph and sr. The block has no timeout.
- After an R or an error, the next J/K can be accepted once 10 new bits have shifted in. Overlapping the old window is allowed.

## Configuration
- DEC4B5B_MAXLEN_EN defined:
  - A nibble counter counts data o_valid strobes in S_DATA.
  - Reaching P_MAX_NIBBLES+1 data nibbles forces: o_rx_er<=1, o_rx_dv<=0, go to S_HUNT. The offending nibble is not reported with o_valid.
- Not defined: no counter is built and frame length is unlimited.

## Test plan
- Reset, then a bit stream of 11111 repeated, J, K, 0x5 (01011), 0xD (11011), T, R -> two o_valid strobes with o_data 5 then D. o_rx_dv is high across both nibbles and low on T. o_frame_done pulses once; o_rx_er stays 0.
- Same frame shifted by 3 idle bits, with i_bit_en toggling every other cycle -> identical output sequence, each strobe 1 cycle wide.
- Invalid code group 00000 between two data nibbles -> o_valid with o_rx_er=1 and o_data=0, o_rx_dv stays 1, frame continues and ends with o_frame_done.
- J, K, 0x1, then 11111 -> o_rx_er pulse, o_rx_dv falls, no o_frame_done. A following J/K frame decodes normally.
- T followed by 11111 instead of R -> o_rx_er pulse, no o_frame_done, state returns to S_HUNT.
- DEC4B5B_MAXLEN_EN with P_MAX_NIBBLES=4, frame of 5 data nibbles -> 4 o_valid strobes, then o_rx_er and o_rx_dv=0. Assert i_res_n low mid-frame in a separate run -> all outputs 0, and the next J/K is accepted.

Source files
------------

// File: rtl/dec4b5b_if.sv
// Receive-side stream bundle for the 4B/5B decoder: recovered bit input and decoded nibble outputs.
interface dec4b5b_if;
    logic       i_bit;
    logic       i_bit_en;
    logic [3:0] o_data;
    logic       o_valid;
    logic       o_rx_dv;
    logic       o_rx_er;
    logic       o_frame_done;

    modport slave (
        input  i_bit,
        input  i_bit_en,
        output o_data,
        output o_valid,
        output o_rx_dv,
        output o_rx_er,
        output o_frame_done
    );

    modport master (
        output i_bit,
        output i_bit_en,
        input  o_data,
        input  o_valid,
        input  o_rx_dv,
        input  o_rx_er,
        input  o_frame_done
    );
endinterface

// File: rtl/dec4b5b.sv
// 100BASE-FX receive 4B/5B decoder: J/K hunt, code-group alignment, nibble decode, T/R end detection.
// Optional frame length limit enabled by defining DEC4B5B_MAXLEN_EN.
//
// state  | meaning
// S_HUNT | searching the bit stream for the J/K start delimiter
// S_DATA | aligned, decoding data code groups until T or IDLE
// S_END  | T seen, waiting for the closing R code group
module dec4b5b #(
    parameter int P_MAX_NIBBLES = 3056
) (
    input logic       i_clk,
    input logic       i_res_n,
    dec4b5b_if.slave  rx
);

    if (P_MAX_NIBBLES < 1) begin : g_bad_cfg
        $error("dec4b5b: P_MAX_NIBBLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_HUNT,
        S_DATA,
        S_END
    } state_t;

    typedef enum logic [2:0] {
        CG_DATA,
        CG_T,
        CG_R,
        CG_IDLE,
        CG_BAD
    } cg_kind_t;

    typedef struct packed {
        cg_kind_t   kind;
        logic [3:0] nib;
    } cg_dec_t;

    localparam logic [9:0] C_JK   = 10'b11000_10001;
    localparam logic [2:0] C_PH_L = 3'd4;

    function automatic cg_dec_t decode_cg(input logic [4:0] cg);
        cg_dec_t d;
        d.kind = CG_DATA;
        d.nib  = 4'h0;
        unique case (cg)
            5'b11110: d.nib = 4'h0;
            5'b01001: d.nib = 4'h1;
            5'b10100: d.nib = 4'h2;
            5'b10101: d.nib = 4'h3;
            5'b01010: d.nib = 4'h4;
            5'b01011: d.nib = 4'h5;
            5'b01110: d.nib = 4'h6;
            5'b01111: d.nib = 4'h7;
            5'b10010: d.nib = 4'h8;
            5'b10011: d.nib = 4'h9;
            5'b10110: d.nib = 4'hA;
            5'b10111: d.nib = 4'hB;
            5'b11010: d.nib = 4'hC;
            5'b11011: d.nib = 4'hD;
            5'b11100: d.nib = 4'hE;
            5'b11101: d.nib = 4'hF;
            5'b01101: d.kind = CG_T;
            5'b00111: d.kind = CG_R;
            5'b11111: d.kind = CG_IDLE;
            default:  d.kind = CG_BAD;
        endcase
        return d;
    endfunction

    state_t     state, state_nxt;
    logic [9:0] sr;
    logic [2:0] ph, ph_nxt;
    logic [3:0] data_q, data_nxt;
    logic       valid_q, valid_nxt;
    logic       dv_q, dv_nxt;
    logic       er_q, er_nxt;
    logic       done_q, done_nxt;

    logic [9:0] window;
    logic [4:0] cg;
    cg_dec_t    dec;
    logic       cg_last;
    logic       len_hit;

    assign window  = {sr[8:0], rx.i_bit};
    assign cg      = {sr[3:0], rx.i_bit};
    assign dec     = decode_cg(cg);
    assign cg_last = rx.i_bit_en && (ph == C_PH_L);

`ifdef DEC4B5B_MAXLEN_EN
    localparam int CNT_W = $clog2(P_MAX_NIBBLES + 1);

    logic [CNT_W-1:0] nib_cnt;

    // Cleared at every J/K so each frame is measured on its own.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            nib_cnt <= '0;
        end else if (rx.i_bit_en) begin
            if (state == S_HUNT && window == C_JK) begin
                nib_cnt <= '0;
            end else if (state == S_DATA && cg_last && dec.kind == CG_DATA && !len_hit) begin
                nib_cnt <= nib_cnt + 1'b1;
            end
        end
    end

    assign len_hit = (nib_cnt == CNT_W'(P_MAX_NIBBLES));
`else
    assign len_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sr <= '0;
        end else if (rx.i_bit_en) begin
            sr <= window;
        end
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state   <= S_HUNT;
            ph      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ph      <= ph_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            dv_q    <= dv_nxt;
            er_q    <= er_nxt;
            done_q  <= done_nxt;
        end
    end

    // Strobes default low every cycle so they stay one clock wide under back-to-back i_bit_en.
    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        dv_nxt    = dv_q;
        er_nxt    = 1'b0;
        done_nxt  = 1'b0;

        if (rx.i_bit_en) begin
            unique case (state)
                S_HUNT: begin
                    if (window == C_JK) begin
                        state_nxt = S_DATA;
                        ph_nxt    = '0;
                    end
                end

                S_DATA: begin
                    if (cg_last) begin
                        ph_nxt = '0;
                        unique case (dec.kind)
                            CG_DATA: begin
                                if (len_hit) begin
                                    er_nxt    = 1'b1;
                                    dv_nxt    = 1'b0;
                                    state_nxt = S_HUNT;
                                end else begin
                                    data_nxt  = dec.nib;
                                    valid_nxt = 1'b1;
                                    dv_nxt    = 1'b1;
                                end
                            end
                            CG_T: begin
                                dv_nxt    = 1'b0;
                                state_nxt = S_END;
                            end
                            CG_IDLE: begin
                                er_nxt    = 1'b1;
                                dv_nxt    = 1'b0;
                                state_nxt = S_HUNT;
                            end
                            default: begin
                                data_nxt  = 4'h0;
                                valid_nxt = 1'b1;
                                er_nxt    = 1'b1;
                            end
                        endcase
                    end else begin
                        ph_nxt = ph + 3'd1;
                    end
                end

                S_END: begin
                    if (cg_last) begin
                        ph_nxt    = '0;
                        state_nxt = S_HUNT;
                        if (dec.kind == CG_R) begin
                            done_nxt = 1'b1;
                        end else begin
                            er_nxt = 1'b1;
                        end
                    end else begin
                        ph_nxt = ph + 3'd1;
                    end
                end

                default: begin
                    state_nxt = S_HUNT;
                    ph_nxt    = '0;
                end
            endcase
        end
    end

    assign rx.o_data       = data_q;
    assign rx.o_valid      = valid_q;
    assign rx.o_rx_dv      = dv_q;
    assign rx.o_rx_er      = er_q;
    assign rx.o_frame_done = done_q;

endmodule

// File: tb/tb_dec4b5b.sv
// Directed bench for dec4b5b: frames with hand-decoded nibbles, error cases, length limit and reset.
module tb_dec4b5b;

    localparam logic [4:0] CG_J    = 5'b11000;
    localparam logic [4:0] CG_K    = 5'b10001;
    localparam logic [4:0] CG_T    = 5'b01101;
    localparam logic [4:0] CG_R    = 5'b00111;
    localparam logic [4:0] CG_IDLE = 5'b11111;
    localparam logic [4:0] CG_BAD  = 5'b00000;

    logic i_clk   = 1'b0;
    logic i_res_n = 1'b0;
    logic gap     = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    dec4b5b_if bus ();

    dec4b5b #(.P_MAX_NIBBLES(4)) u_dut (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .rx      (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    logic [3:0] rec_data[$];
    logic       rec_er[$];
    logic       rec_dv[$];
    int         n_er, n_done, n_wide;
    logic       prev_v, prev_e, prev_d;

    always @(negedge i_clk) begin
        if (bus.o_valid) begin
            rec_data.push_back(bus.o_data);
            rec_er.push_back(bus.o_rx_er);
            rec_dv.push_back(bus.o_rx_dv);
        end
        if (bus.o_rx_er)      n_er++;
        if (bus.o_frame_done) n_done++;
        if ((bus.o_valid && prev_v) || (bus.o_rx_er && prev_e) || (bus.o_frame_done && prev_d))
            n_wide++;
        prev_v = bus.o_valid;
        prev_e = bus.o_rx_er;
        prev_d = bus.o_frame_done;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_nib(input string tag, input int idx, input int exp_d, input int exp_er);
        if (idx < rec_data.size()) begin
            chk({tag, "_data"}, int'(rec_data[idx]), exp_d);
            chk({tag, "_er"}, int'(rec_er[idx]), exp_er);
            chk({tag, "_dv"}, int'(rec_dv[idx]), 1);
        end else begin
            chk({tag, "_missing"}, -1, exp_d);
        end
    endtask

    task automatic clear_rec();
        rec_data.delete();
        rec_er.delete();
        rec_dv.delete();
        n_er   = 0;
        n_done = 0;
        n_wide = 0;
    endtask

    task automatic send_bit(input logic b);
        @(posedge i_clk);
        #1;
        bus.i_bit    = b;
        bus.i_bit_en = 1'b1;
        if (gap) begin
            @(posedge i_clk);
            #1;
            bus.i_bit_en = 1'b0;
        end
    endtask

    task automatic send_cg(input logic [4:0] cg);
        for (int i = 4; i >= 0; i--) send_bit(cg[i]);
    endtask

    task automatic pause(input int n);
        @(posedge i_clk);
        #1;
        bus.i_bit_en = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_jk();
        send_cg(CG_J);
        send_cg(CG_K);
    endtask

    initial begin
        prev_v       = 1'b0;
        prev_e       = 1'b0;
        prev_d       = 1'b0;
        bus.i_bit    = 1'b0;
        bus.i_bit_en = 1'b0;
        clear_rec();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data",  int'(bus.o_data), 0);
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_dv",    int'(bus.o_rx_dv), 0);
        chk("rst_er",    int'(bus.o_rx_er), 0);
        chk("rst_done",  int'(bus.o_frame_done), 0);
        i_res_n = 1'b1;

        // Basic frame: 5, D, T, R.
        clear_rec();
        repeat (3) send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b01011);
        send_cg(5'b11011);
        send_cg(CG_T);
        send_cg(CG_R);
        send_cg(CG_IDLE);
        pause(3);
        chk("f1_count", rec_data.size(), 2);
        chk_nib("f1_n0", 0, 5, 0);
        chk_nib("f1_n1", 1, 13, 0);
        chk("f1_done", n_done, 1);
        chk("f1_er", n_er, 0);
        chk("f1_dv_end", int'(bus.o_rx_dv), 0);
        chk("f1_wide", n_wide, 0);

        // Same frame, shifted by 3 bits, with i_bit_en every other cycle.
        clear_rec();
        gap = 1'b1;
        repeat (3) send_bit(1'b1);
        repeat (2) send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b01011);
        send_cg(5'b11011);
        send_cg(CG_T);
        send_cg(CG_R);
        send_cg(CG_IDLE);
        pause(3);
        gap = 1'b0;
        chk("f2_count", rec_data.size(), 2);
        chk_nib("f2_n0", 0, 5, 0);
        chk_nib("f2_n1", 1, 13, 0);
        chk("f2_done", n_done, 1);
        chk("f2_er", n_er, 0);
        chk("f2_wide", n_wide, 0);

        // Invalid code group in mid-frame.
        clear_rec();
        send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b01011);
        send_cg(CG_BAD);
        send_cg(5'b11011);
        send_cg(CG_T);
        send_cg(CG_R);
        pause(3);
        chk("f3_count", rec_data.size(), 3);
        chk_nib("f3_n0", 0, 5, 0);
        chk_nib("f3_n1", 1, 0, 1);
        chk_nib("f3_n2", 2, 13, 0);
        chk("f3_er", n_er, 1);
        chk("f3_done", n_done, 1);

        // Premature IDLE, then a clean frame.
        clear_rec();
        send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b01001);
        send_cg(CG_IDLE);
        pause(3);
        chk("f4_count", rec_data.size(), 1);
        chk_nib("f4_n0", 0, 1, 0);
        chk("f4_er", n_er, 1);
        chk("f4_done", n_done, 0);
        chk("f4_dv", int'(bus.o_rx_dv), 0);
        clear_rec();
        send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b01110);
        send_cg(CG_T);
        send_cg(CG_R);
        pause(3);
        chk("f4b_count", rec_data.size(), 1);
        chk_nib("f4b_n0", 0, 6, 0);
        chk("f4b_done", n_done, 1);
        chk("f4b_er", n_er, 0);

        // T followed by IDLE instead of R, then a clean frame proves HUNT.
        clear_rec();
        send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b10101);
        send_cg(CG_T);
        send_cg(CG_IDLE);
        pause(3);
        chk("f5_count", rec_data.size(), 1);
        chk_nib("f5_n0", 0, 3, 0);
        chk("f5_er", n_er, 1);
        chk("f5_done", n_done, 0);
        clear_rec();
        send_jk();
        send_cg(5'b01111);
        send_cg(CG_T);
        send_cg(CG_R);
        pause(3);
        chk("f5b_count", rec_data.size(), 1);
        chk_nib("f5b_n0", 0, 7, 0);
        chk("f5b_done", n_done, 1);

        // Five data nibbles against a limit of four.
        clear_rec();
        send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b11110);
        send_cg(5'b01001);
        send_cg(5'b10100);
        send_cg(5'b10101);
        send_cg(5'b01010);
        send_cg(CG_T);
        send_cg(CG_R);
        pause(3);
        chk_nib("f6_n0", 0, 0, 0);
        chk_nib("f6_n3", 3, 3, 0);
        chk("f6_dv", int'(bus.o_rx_dv), 0);
`ifdef DEC4B5B_MAXLEN_EN
        chk("f6_count", rec_data.size(), 4);
        chk("f6_er", n_er, 1);
        chk("f6_done", n_done, 0);
`else
        chk("f6_count", rec_data.size(), 5);
        chk_nib("f6_n4", 4, 4, 0);
        chk("f6_er", n_er, 0);
        chk("f6_done", n_done, 1);
`endif

        // Reset in the middle of a frame.
        clear_rec();
        send_cg(CG_IDLE);
        send_jk();
        send_cg(5'b10010);
        send_bit(1'b1);
        send_bit(1'b0);
        pause(1);
        chk("f7_dv_pre", int'(bus.o_rx_dv), 1);
        i_res_n = 1'b0;
        #2;
        chk("f7_rst_data", int'(bus.o_data), 0);
        chk("f7_rst_dv",   int'(bus.o_rx_dv), 0);
        chk("f7_rst_valid", int'(bus.o_valid), 0);
        chk("f7_rst_er",   int'(bus.o_rx_er), 0);
        chk("f7_rst_done", int'(bus.o_frame_done), 0);
        pause(2);
        clear_rec();
        i_res_n = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_cg(CG_IDLE);
        pause(2);
        chk("f7_quiet", rec_data.size() + n_er + n_done, 0);
        send_jk();
        send_cg(5'b10110);
        send_cg(CG_T);
        send_cg(CG_R);
        pause(3);
        chk("f7_count", rec_data.size(), 1);
        chk_nib("f7_n0", 0, 10, 0);
        chk("f7_done", n_done, 1);
        chk("f7_er", n_er, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
